// File: rtl/commit_checker.sv
// commit_checker_fifo: small synchronous FIFO holding one side's {addr, data} store entries.
// Latency: a push is visible in level_o and head_o one cycle after the strobe edge.
// Backpressure: none; a push while full is accepted only when the same edge also pops.
module commit_checker_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [W-1:0]             dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q, level_q;
    logic          push_ok, pop_ok;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign level_o = level_q;

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[wptr_q[AW-1:0]] <= dat_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop_ok)  rptr_q <= rptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + PW'(1);
                2'b01:   level_q <= level_q - PW'(1);
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// commit_checker: in-order compare of golden and pipelined store streams with first-failure capture.
// Latency: level updates 1 cycle after a strobe; a compare result appears 2 cycles after the later strobe.
// Backpressure: none; a push into a full FIFO without a same-cycle compare is dropped and flagged.
module commit_checker #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    g_wr_i,
    input  logic [ADDR_WIDTH-1:0]   g_addr_i,
    input  logic [DATA_WIDTH-1:0]   g_data_i,
    input  logic                    d_wr_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_data_i,
    output logic [CNT_WIDTH-1:0]    match_count_o,
    output logic [CNT_WIDTH-1:0]    mismatch_count_o,
    output logic                    error_o,
    output logic [1:0]              err_code_o,
    output logic [ADDR_WIDTH-1:0]   first_g_addr_o,
    output logic [ADDR_WIDTH-1:0]   first_d_addr_o,
    output logic [DATA_WIDTH-1:0]   first_g_data_o,
    output logic [DATA_WIDTH-1:0]   first_d_data_o,
    output logic [$clog2(DEPTH):0]  g_level_o,
    output logic [$clog2(DEPTH):0]  d_level_o,
    output logic [1:0]              state_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_FAULT   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISMATCH = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_e;

    logic [EW-1:0]         g_head, d_head;
    logic                  g_full, g_empty, d_full, d_empty;
    logic [LW-1:0]         g_level, d_level;
    logic                  do_cmp, pair_eq;
    logic                  mis_fail, ovf_fail, tmo_fail, any_fail, occ_nxt;
    logic [TW-1:0]         lag_q, lag_d;
    state_e                state_q;
    err_e                  err_code_q;
    logic                  error_q;
    logic [CNT_WIDTH-1:0]  match_q, mismatch_q;
    logic [ADDR_WIDTH-1:0] fg_addr_q, fd_addr_q;
    logic [DATA_WIDTH-1:0] fg_data_q, fd_data_q;

    commit_checker_fifo #(.W(EW), .DEPTH(DEPTH)) u_g_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (g_wr_i),
        .dat_i   ({g_addr_i, g_data_i}),
        .pop_i   (do_cmp),
        .head_o  (g_head),
        .full_o  (g_full),
        .empty_o (g_empty),
        .level_o (g_level)
    );

    commit_checker_fifo #(.W(EW), .DEPTH(DEPTH)) u_d_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (d_wr_i),
        .dat_i   ({d_addr_i, d_data_i}),
        .pop_i   (do_cmp),
        .head_o  (d_head),
        .full_o  (d_full),
        .empty_o (d_empty),
        .level_o (d_level)
    );

    // Both heads present means one in-order compare this edge; both FIFOs pop together.
    assign do_cmp   = !g_empty && !d_empty;
    assign pair_eq  = (g_head == d_head);
    assign mis_fail = do_cmp && !pair_eq;
    // A full FIFO only accepts a push when the compare pops it in the same edge.
    assign ovf_fail = !do_cmp && ((g_wr_i && g_full) || (d_wr_i && d_full));
    assign tmo_fail = (lag_d == TW'(TIMEOUT));
    assign any_fail = mis_fail || ovf_fail || tmo_fail;
    // Occupancy after this edge: any push keeps a FIFO non-empty, otherwise level minus pop.
    assign occ_nxt  = g_wr_i || d_wr_i ||
                      (g_level != LW'(do_cmp)) || (d_level != LW'(do_cmp));

    // Watchdog: counts cycles where only one side holds entries, saturating at the limit.
    always_comb begin
        lag_d = lag_q;
        if (g_empty == d_empty) begin
            lag_d = '0;
        end else if (lag_q != TW'(TIMEOUT)) begin
            lag_d = lag_q + TW'(1);
        end
    end

    // Checker state machine, counters and first-failure capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            error_q    <= 1'b0;
            lag_q      <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
            fg_addr_q  <= '0;
            fd_addr_q  <= '0;
            fg_data_q  <= '0;
            fd_data_q  <= '0;
        end else if (clear_i) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            error_q    <= 1'b0;
            lag_q      <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
            fg_addr_q  <= '0;
            fd_addr_q  <= '0;
            fg_data_q  <= '0;
            fd_data_q  <= '0;
        end else begin
            lag_q <= lag_d;
            if (do_cmp && pair_eq && (match_q != '1)) begin
                match_q <= match_q + CNT_WIDTH'(1);
            end
            if (mis_fail && (mismatch_q != '1)) begin
                mismatch_q <= mismatch_q + CNT_WIDTH'(1);
            end
            if (!error_q && any_fail) begin
                error_q <= 1'b1;
                if (mis_fail) begin
                    err_code_q <= ERR_MISMATCH;
                    fg_addr_q  <= g_head[EW-1 -: ADDR_WIDTH];
                    fg_data_q  <= g_head[DATA_WIDTH-1:0];
                    fd_addr_q  <= d_head[EW-1 -: ADDR_WIDTH];
                    fd_data_q  <= d_head[DATA_WIDTH-1:0];
                end else if (ovf_fail) begin
                    err_code_q <= ERR_OVERFLOW;
                end else begin
                    err_code_q <= ERR_TIMEOUT;
                end
            end
            case (state_q)
                ST_FAULT: state_q <= ST_FAULT;
                default: begin
                    if (any_fail)     state_q <= ST_FAULT;
                    else if (occ_nxt) state_q <= ST_PENDING;
                    else              state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign match_count_o    = match_q;
    assign mismatch_count_o = mismatch_q;
    assign error_o          = error_q;
    assign err_code_o       = err_code_q;
    assign first_g_addr_o   = fg_addr_q;
    assign first_d_addr_o   = fd_addr_q;
    assign first_g_data_o   = fg_data_q;
    assign first_d_data_o   = fd_data_q;
    assign g_level_o        = g_level;
    assign d_level_o        = d_level;
    assign state_o          = state_q;
endmodule
